slot_freelist: RTL
==================

# slot_freelist

Tracks a pool of WIDTH allocatable slots (ROB/RS/physical-register style) and serves up to REQS allocations and REQS releases per cycle. Grants come from an internal alternating low/high priority pick over the free vector, returned as binary slot indices. Releases arrive as binary indices and are decoded back into the free vector. This block sits between dispatch (allocation) and retire/complete (release).

## Interface
- WIDTH, 32: number of slots; power of two, ≥4.
- REQS, 2: allocation lanes and release lanes; 1 ≤ REQS ≤ WIDTH.
- IDX_W, 5: slot index width, equal to log2(WIDTH).
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high.
- alloc_req  in  REQS  lane k requests one slot this cycle.
- alloc_gnt  out  REQS  lane k granted this cycle (combinational).
- alloc_idx  out  REQS*IDX_W  slot for lane k, bits [(k+1)*IDX_W-1 -: IDX_W]; 0 when not granted.
- free_valid  in  REQS  lane k releases a slot this cycle.
- free_idx  in  REQS*IDX_W  slot released by lane k.
- free_vec  out  WIDTH  registered; bit i=1 means slot i is free.
- free_cnt  out  IDX_W+1  registered popcount of free_vec.
- none_free  out  1  registered; high when free_cnt==0.

## Operation
- Available set: avail = free_vec. With bypass configured, avail = free_vec | release mask.
- Requesting lanes are ranked by ascending lane number, skipping idle lanes. The r-th requesting lane (r from 0) is assigned as follows:
  - r even: the (r/2)-th lowest-index slot in avail.
  - r odd: the (r/2)-th highest-index slot in avail.
- A lane is denied when its candidate collides with a slot already given to a lower-ranked lane, or no candidate exists. A denied lane has gnt=0 and idx=0. Grants are always distinct.
- Example: one free slot, two requesters. Lane rank 0 gets the slot; rank 1 is denied.
- alloc_mask = OR of one-hot(alloc_idx[k]) over granted lanes.
- Release decode: free_mask = OR of one-hot(free_idx[k]) over valid lanes. Duplicate indices across lanes are idempotent.
- Next-state, no bypass: free_vec <= (free_vec & ~alloc_mask) | free_mask.
- Next-state, bypass: free_vec <= avail & ~alloc_mask.
- free_cnt <= popcount(next free_vec); none_free <= (popcount==0).
- Releasing an already-free slot is a protocol error. Without bypass it has no further effect; the slot simply stays free.
- No FSM beyond the free-vector register; the register, count and flag are the only state.

## Timing
- Reset (async assert, sync-to-edge deassert): free_vec=all ones, free_cnt=WIDTH, none_free=0.
- While reset is high: alloc_gnt=0 and alloc_idx=0.
- Reset mid-operation discards all outstanding allocations; the pool is fully free.
- Allocation latency is 0 cycles: gnt/idx are valid in the same cycle as alloc_req. The slot leaves free_vec at the next edge.
- Handshake: requesters sample alloc_gnt in the same cycle; there is no hold or retry. A denied lane re-requests in a later cycle.
- Release takes effect at the next edge. Without bypass, the slot becomes allocatable one cycle after free_valid.
- free_cnt and none_free reflect the register, not the current cycle's alloc/free.

## Configuration
- FREELIST_BYPASS_EN defined: slots released in cycle t are allocatable in cycle t. Release-then-allocate of the same slot in one cycle leaves it busy. Adds a combinational path from free_idx to alloc_gnt/alloc_idx.
- FREELIST_BYPASS_EN undefined: there is no path from free inputs to allocation outputs, and a release is visible one cycle later.

## Test plan
All scenarios use WIDTH=8, REQS=2.
- Reset, then alloc_req=2'b11 → lane0 idx=0, lane1 idx=7, both granted; next cycle free_vec=8'h7E, free_cnt=6.
- free_vec=8'h10, alloc_req=2'b11 → lane0 gnt, idx=4; lane1 gnt=0, idx=0; next free_vec=0, none_free=1.
- alloc_req=2'b10 only, free_vec=8'hFF → lane1 ranked 0, gets idx=0.
- free_vec=0, free_valid=2'b11 with idx 3 and 3, alloc_req=2'b01:
  - Without bypass: gnt=0, next free_vec=8'h08.
  - With bypass: lane0 gets idx=3, next free_vec=0.
- Allocate until none_free=1, then release idx 5 and 2 in the same cycle → next cycle free_cnt=2; alloc_req=2'b11 yields idx 2 and 5.
- Assert reset asynchronously mid-cycle with free_vec=8'h01 → free_vec=8'hFF and free_cnt=8 immediately, without waiting for a clock edge; alloc_gnt=0 while reset is held.

Source files
------------

// File: rtl/slot_freelist.sv
// rtl/slot_freelist.sv - slot pool free list with multi-lane allocate/release
// Define FREELIST_BYPASS_EN to make same-cycle releases allocatable.
module slot_freelist #(
  parameter int WIDTH = 32,
  parameter int REQS  = 2,
  parameter int IDX_W = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REQS-1:0]       alloc_req,
  output logic [REQS-1:0]       alloc_gnt,
  output logic [REQS*IDX_W-1:0] alloc_idx,
  input  logic [REQS-1:0]       free_valid,
  input  logic [REQS*IDX_W-1:0] free_idx,
  output logic [WIDTH-1:0]      free_vec,
  output logic [IDX_W:0]        free_cnt,
  output logic                  none_free
);

  logic [WIDTH-1:0]      free_mask;
  logic [WIDTH-1:0]      avail;
  logic [WIDTH-1:0]      alloc_mask;
  logic [WIDTH-1:0]      free_vec_nxt;
  logic [REQS-1:0]       gnt_raw;
  logic [REQS*IDX_W-1:0] idx_raw;

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [WIDTH-1:0] v);
    lowest_idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDX_W'(i);
    end
  endfunction

  function automatic logic [IDX_W-1:0] highest_idx(input logic [WIDTH-1:0] v);
    highest_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) highest_idx = IDX_W'(i);
    end
  endfunction

  function automatic logic [IDX_W:0] popcount(input logic [WIDTH-1:0] v);
    popcount = '0;
    for (int i = 0; i < WIDTH; i++) begin
      popcount = popcount + {{IDX_W{1'b0}}, v[i]};
    end
  endfunction

  always_comb begin
    free_mask = '0;
    for (int k = 0; k < REQS; k++) begin
      if (free_valid[k]) free_mask[free_idx[k*IDX_W +: IDX_W]] = 1'b1;
    end
  end

`ifdef FREELIST_BYPASS_EN
  assign avail = free_vec | free_mask;
`else
  assign avail = free_vec;
`endif

  // Even ranks consume from the low end, odd ranks from the high end; the two
  // ends only meet when the pool runs short, which shows up as a collision.
  always_comb begin
    logic [WIDTH-1:0] lo_mask;
    logic [WIDTH-1:0] hi_mask;
    logic [WIDTH-1:0] given;
    logic             pick_hi;
    logic             found;
    logic [IDX_W-1:0] cand;
    lo_mask = avail;
    hi_mask = avail;
    given   = '0;
    pick_hi = 1'b0;
    found   = 1'b0;
    cand    = '0;
    gnt_raw = '0;
    idx_raw = '0;
    for (int k = 0; k < REQS; k++) begin
      if (alloc_req[k]) begin
        if (!pick_hi) begin
          found = |lo_mask;
          cand  = lowest_idx(lo_mask);
          if (found) lo_mask[cand] = 1'b0;
        end else begin
          found = |hi_mask;
          cand  = highest_idx(hi_mask);
          if (found) hi_mask[cand] = 1'b0;
        end
        pick_hi = ~pick_hi;
        if (found && !given[cand]) begin
          gnt_raw[k]                 = 1'b1;
          idx_raw[k*IDX_W +: IDX_W]  = cand;
          given[cand]                = 1'b1;
        end
      end
    end
    alloc_mask = given;
  end

  assign alloc_gnt = reset ? '0 : gnt_raw;
  assign alloc_idx = reset ? '0 : idx_raw;

`ifdef FREELIST_BYPASS_EN
  assign free_vec_nxt = avail & ~alloc_mask;
`else
  assign free_vec_nxt = (free_vec & ~alloc_mask) | free_mask;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      free_vec  <= '1;
      free_cnt  <= (IDX_W+1)'(WIDTH);
      none_free <= 1'b0;
    end else begin
      free_vec  <= free_vec_nxt;
      free_cnt  <= popcount(free_vec_nxt);
      none_free <= (popcount(free_vec_nxt) == '0);
    end
  end

endmodule
